t07_button_strobe: RTL

T07_BUTTON_STROBE -- requirements
Module: t07_button_strobe

---
 rtl/t07_button_strobe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/t07_button_strobe.sv
// t07_button_strobe
// Debounces a bank of six one-hot pushbuttons {BACK,LEFT,DOWN,RIGHT,UP,SELECT}
// and presents the accepted code on 'button', followed two cycles later by a
// single-cycle 'strobe' telling the game logic when to consume it.
// Optional feature: define T07_AUTOREPEAT_EN to re-issue the strobe every
// REPEAT_CYCLES cycles while the button stays held.
module t07_button_strobe #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [5:0] pb_in,
    output logic [5:0] button,
    output logic       strobe
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SETTLE,
        PULSE,
        HOLD,
        RELEASE
    } state_t;

    state_t             state;
    logic [5:0]         sync_meta;
    logic [5:0]         sync;
    logic [5:0]         cand;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               sync_valid;

`ifdef T07_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0]   rep_cnt;
`endif

    // A press candidate must have exactly one bit set; idle or chorded inputs are ignored.
    assign sync_valid = (sync != 6'd0) && ((sync & (sync - 6'd1)) == 6'd0);

    // The shared counter sticks at all-ones rather than wrapping back to zero.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // Two-flop synchronizer bringing the raw buttons into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= pb_in;
            sync      <= sync_meta;
        end
    end

    // Press/release debouncer with registered button code and consume strobe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            cand   <= '0;
            cnt    <= '0;
            button <= '0;
            strobe <= 1'b0;
`ifdef T07_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            strobe <= 1'b0;
            case (state)
                IDLE: begin
                    button <= '0;
                    if (sync_valid) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end

                DEBOUNCE: begin
                    if (sync == cand) begin
                        if (cnt == DEB_LAST) begin
                            button <= cand;
                            cnt    <= '0;
                            state  <= SETTLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end

                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt    <= '0;
                        strobe <= 1'b1;
                        state  <= PULSE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                PULSE: begin
                    state <= HOLD;
`ifdef T07_AUTOREPEAT_EN
                    rep_cnt <= '0;
`endif
                end

                HOLD: begin
                    if (sync != button) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
`ifdef T07_AUTOREPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        strobe  <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + CNT_W'(1);
                    end
`endif
                end

                RELEASE: begin
                    if (sync == 6'd0) begin
                        if (cnt == DEB_LAST) begin
                            button <= '0;
                            cnt    <= '0;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                default: begin
                    button <= '0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
